// File: rtl/util_axis_uart_pkg.sv
// Shared types and constants for the oversampling AXI-Stream UART receiver.
package util_axis_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } uart_state_e;

  localparam int PARITY_EVEN  = 0;
  localparam int PARITY_ODD   = 1;
  localparam int PARITY_MARK  = 2;
  localparam int PARITY_SPACE = 3;

  localparam int TUSER_PERR  = 0;
  localparam int TUSER_FERR  = 1;
  localparam int TUSER_BREAK = 2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/util_uart_baud_tick.sv
// Oversample prescaler: down-counter emitting a one-cycle tick every DIV cycles.
// clr_i restarts the period so the first tick lands DIV cycles later.
module util_uart_baud_tick #(
  parameter int unsigned DIV = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q - 1'b1;
    if (clr_i || tick_o) cnt_d = RELOAD;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/util_axis_uart_rx_os.sv
// Oversampling UART receiver with AXI-Stream output and 2-of-3 mid-bit voting.
// Optional break flag on tuser[2] enabled by UTIL_AXIS_UART_RX_BREAK_DET_EN.
//
// state        | meaning
// IDLE         | line idle, waiting for synchronized falling edge
// START        | validating start bit at mid-bit
// DATA         | shifting data bits LSB-first
// PARITY       | sampling parity bit
// STOP         | sampling stop bit(s); character completes at last mid-stop
// WAIT_HIGH    | line stuck low after a bad stop, wait for it to return high
module util_axis_uart_rx_os
  import util_axis_uart_pkg::*;
#(
  parameter int baud_clock_speed = 50000000,
  parameter int baud_rate        = 1000000,
  parameter int data_bits        = 8,
  parameter int parity_ena       = 0,
  parameter int parity_type      = 0,
  parameter int stop_bits        = 1,
  parameter int oversample       = 16
) (
  input  logic                 aclk,
  input  logic                 arst,
  input  logic                 rx,
  output logic [data_bits-1:0] m_axis_tdata,
  output logic [2:0]           m_axis_tuser,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 overrun
);

  localparam int DIV = baud_clock_speed / (baud_rate * oversample);
  localparam int SCW = $clog2(oversample);
  localparam logic [SCW-1:0] S_LO   = SCW'(oversample / 2 - 1);
  localparam logic [SCW-1:0] S_MID  = SCW'(oversample / 2);
  localparam logic [SCW-1:0] S_HI   = SCW'(oversample / 2 + 1);
  localparam logic [SCW-1:0] S_LAST = SCW'(oversample - 1);
  localparam logic [3:0]     DB_LAST   = 4'(data_bits - 1);
  localparam logic           STOP_LAST = 1'(stop_bits - 1);

  if (DIV < 1) begin : g_div_err
    $error("util_axis_uart_rx_os: clock too slow for baud_rate*oversample");
  end
  if (oversample < 8 || (oversample % 2) != 0) begin : g_os_err
    $error("util_axis_uart_rx_os: oversample must be even and >= 8");
  end
  if (data_bits < 5 || data_bits > 9) begin : g_db_err
    $error("util_axis_uart_rx_os: data_bits must be 5..9");
  end

  logic sync1_q, rx_s_q, rx_prev_q;
  uart_state_e state_q, state_d;
  logic [SCW-1:0] samp_q, samp_d;
  logic [1:0] vote_q, vote_d;
  logic [3:0] bit_q, bit_d;
  logic stop_q, stop_d;
  logic [data_bits-1:0] shift_q, shift_d;
  logic perr_q, perr_d, ferr_q, ferr_d;
  logic [data_bits-1:0] tdata_q;
  logic [2:0] tuser_q;
  logic tvalid_q, ovr_q;
  logic tick, clr, mid, bit_val, par_exp, done, ferr_char, brk_char;

  util_uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk_i  (aclk),
    .rst_i  (arst),
    .clr_i  (clr),
    .tick_o (tick)
  );

  assign mid     = tick && (samp_q == S_HI);
  assign bit_val = maj3(vote_q[0], vote_q[1], rx_s_q);

  always_comb begin
    case (parity_type)
      PARITY_EVEN: par_exp = ^shift_q;
      PARITY_ODD:  par_exp = ~^shift_q;
      PARITY_MARK: par_exp = 1'b1;
      default:     par_exp = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    samp_d    = samp_q;
    vote_d    = vote_q;
    bit_d     = bit_q;
    stop_d    = stop_q;
    shift_d   = shift_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    clr       = 1'b0;
    done      = 1'b0;
    ferr_char = ferr_q | ~bit_val;
    if (state_q != ST_IDLE && tick) begin
      samp_d = (samp_q == S_LAST) ? '0 : samp_q + 1'b1;
      if (samp_q == S_LO)  vote_d[0] = rx_s_q;
      if (samp_q == S_MID) vote_d[1] = rx_s_q;
    end
    // Every decision is taken at the third vote sample of the current bit.
    case (state_q)
      ST_IDLE: if (rx_prev_q && !rx_s_q) begin
        clr     = 1'b1;
        samp_d  = '0;
        state_d = ST_START;
      end
      ST_START: if (mid) begin
        if (bit_val) state_d = ST_IDLE;
        else begin
          state_d = ST_DATA;
          bit_d   = '0;
          stop_d  = 1'b0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      ST_DATA: if (mid) begin
        shift_d = {bit_val, shift_q[data_bits-1:1]};
        if (bit_q == DB_LAST) state_d = (parity_ena != 0) ? ST_PARITY : ST_STOP;
        else                  bit_d   = bit_q + 1'b1;
      end
      ST_PARITY: if (mid) begin
        perr_d  = bit_val ^ par_exp;
        state_d = ST_STOP;
      end
      ST_STOP: if (mid) begin
        ferr_d = ferr_char;
        if (stop_q == STOP_LAST) begin
          done    = 1'b1;
          state_d = bit_val ? ST_IDLE : ST_WAIT_HIGH;
        end else begin
          stop_d = stop_q + 1'b1;
        end
      end
      ST_WAIT_HIGH: if (rx_s_q) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef UTIL_AXIS_UART_RX_BREAK_DET_EN
  logic brk_q, brk_d;

  always_comb begin
    brk_d    = brk_q;
    brk_char = 1'b0;
    if (mid) begin
      case (state_q)
        ST_START:            brk_d = 1'b1;
        ST_DATA, ST_PARITY:  brk_d = brk_q & ~bit_val;
        ST_STOP: if (stop_q == 1'b0) brk_d = brk_q & ~bit_val;
        default: ;
      endcase
    end
    if (done) brk_char = (stop_q == 1'b0) ? (brk_q & ~bit_val) : brk_q;
  end

  always_ff @(posedge aclk) begin
    if (arst) brk_q <= 1'b0;
    else      brk_q <= brk_d;
  end
`else
  assign brk_char = 1'b0;
`endif

  always_ff @(posedge aclk) begin
    if (arst) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= ST_IDLE;
      samp_q    <= '0;
      vote_q    <= '0;
      bit_q     <= '0;
      stop_q    <= 1'b0;
      shift_q   <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sync1_q   <= rx;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
      state_q   <= state_d;
      samp_q    <= samp_d;
      vote_q    <= vote_d;
      bit_q     <= bit_d;
      stop_q    <= stop_d;
      shift_q   <= shift_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  // A held beat wins over a newly completed one unless it is leaving this cycle.
  always_ff @(posedge aclk) begin
    if (arst) begin
      tdata_q  <= '0;
      tuser_q  <= '0;
      tvalid_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (done) begin
        if (!tvalid_q || m_axis_tready) begin
          tdata_q  <= shift_q;
          tuser_q  <= {brk_char, ferr_char, perr_q};
          tvalid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (tvalid_q && m_axis_tready) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tvalid = tvalid_q;
  assign overrun       = ovr_q;

endmodule

// File: doc/util_axis_uart_rx_os.md
UTIL_AXIS_UART_RX_OS -- requirements
Module: util_axis_uart_rx_os

Interface
REQ-001 Parameters SHALL be, one per line:
- baud_clock_speed, 50000000: aclk frequency in Hz.
- baud_rate, 1000000: line rate in baud.
- data_bits, 8: character width, legal values 5..9.
- parity_ena, 0: 1 = parity bit present.
- parity_type, 0: 0 even, 1 odd, 2 mark, 3 space.
- stop_bits, 1: number of stop bits, 1 or 2.
- oversample, 16: samples per bit, even, at least 8.
REQ-002 Ports SHALL be, one per line:
- aclk, in, 1: sole clock.
- arst, in, 1: synchronous, active-high reset.
- rx, in, 1: asynchronous serial input, idle high.
- m_axis_tdata, out, data_bits: received character, LSB = first bit on the line.
- m_axis_tuser, out, 3: [0] parity error, [1] framing error, [2] break.
- m_axis_tvalid, out, 1: character available.
- m_axis_tready, in, 1: downstream accept.
- overrun, out, 1: one-cycle pulse when a character is dropped.
REQ-003 The design SHALL have one clock, aclk, with reset arst synchronous and active-high; no other clock domain exists.

Function
REQ-004 rx SHALL pass through a 2-flop synchronizer before any use, giving 2 cycles of input latency.
REQ-005 The sample tick SHALL fire every DIV = floor(baud_clock_speed/(baud_rate*oversample)) aclk cycles; DIV < 1 SHALL be an elaboration error.
REQ-006 The states SHALL be IDLE, START, DATA, PARITY, STOP and WAIT_HIGH.
REQ-007 IDLE: on a synchronized 1->0 edge, the FSM SHALL clear the prescaler and sample counter and go to START.
REQ-008 START: if the majority vote at mid-bit is 1, the FSM SHALL treat it as a glitch and return to IDLE with no output; if 0, it SHALL go to DATA.
REQ-009 Each bit value SHALL be the 2-of-3 majority of samples oversample/2-1, oversample/2 and oversample/2+1 of that bit.
REQ-010 DATA SHALL shift data_bits bits LSB-first, then go to PARITY if parity_ena=1, else to STOP.
REQ-011 Parity error SHALL be the sampled parity bit mismatching the expected value: even = XOR of data, odd = its inverse, mark = 1, space = 0.
REQ-012 STOP SHALL sample stop_bits bits; framing error SHALL be set if any stop bit is 0.
REQ-013 At the mid-point of the last stop bit the character SHALL complete, and m_axis_tvalid SHALL assert on the next cycle.
REQ-014 After completion the FSM SHALL go to IDLE if the last stop bit was 1, else to WAIT_HIGH.
REQ-015 WAIT_HIGH SHALL hold until the synchronized rx is 1, then go to IDLE, so that a held-low line yields one character only.
REQ-016 tdata, tuser and tvalid SHALL be held stable while tvalid=1 and tready=0; a transfer occurs on tvalid&&tready, and tvalid deasserts the next cycle unless a new character completes in that same cycle.
REQ-017 If a character completes while tvalid=1 and tready=0, the new character SHALL be dropped, the held one kept, and overrun pulsed high for 1 cycle.
REQ-018 If a character completes in the same cycle as a transfer, the new character SHALL be loaded with no overrun and tvalid SHALL stay 1.

Reset
REQ-019 arst SHALL force state IDLE, synchronizer flops to 1, prescaler and counters to 0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0 and overrun=0.
REQ-020 arst asserted mid-character SHALL discard the partial character, with no tvalid after release until a full new frame arrives.

Configuration
REQ-021 With UTIL_AXIS_UART_RX_BREAK_DET_EN defined, tuser[2] SHALL be set when all data bits, the parity bit if present, and the first stop bit sample 0 (framing error is also set).
REQ-022 Without UTIL_AXIS_UART_RX_BREAK_DET_EN, tuser[2] SHALL be tied 0, a break SHALL be reported as a framing error only, and no break logic SHALL be synthesized.

Structure
REQ-023 Package util_axis_uart_pkg SHALL hold the FSM state enum, the parity_type constants and the tuser bit indices.
REQ-024 The prescaler/tick generator SHALL be the sub-module util_uart_baud_tick, with a synchronous clear input and a one-cycle tick output.

Verification
REQ-025 Bench defaults: 50 MHz clock, 1 Mbaud, oversample 10, so DIV=5.
- Frame 0x41, 8N1, tready=1 -> one beat with tdata=0x41, tuser=0, tvalid asserted 1 cycle after the mid-stop sample.
- 8E1 frame of 0x03 with parity bit 1 -> tdata=0x03, tuser=3'b001; the same frame with parity 0 -> tuser=0.
- Stop bit driven 0 on 0x55 -> tuser[1]=1; rx then held low 30 bit times -> no further beats until rx returns high.
- rx held low 25 bit times with the macro defined -> exactly one beat, tdata=0, tuser=3'b110; without the macro -> tuser=3'b010.
- tready=0, frames 0x10 then 0x20 sent -> tdata stays 0x10, overrun pulses once; tready=1 -> 0x10 is transferred and 0x20 never appears.
- 2-cycle low glitch on idle rx -> no beat; arst asserted mid-frame -> tvalid=0 and the next clean frame 0x7E is received correctly.
